// File: rtl/soc_data_bridge.sv
// Data-side bridge between the core LSU and either the data RAM or a small
// MMIO register window (FLAG, RESULT, free-running CYCLE counter, ID).
module soc_data_bridge #(
    parameter logic [31:0] MMIO_BASE = 32'h0010_0000,
    parameter logic [31:0] MMIO_MASK = 32'hFFFF_FFF0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] flag_o,
    output logic [31:0] result_o,
    output logic        done_o
);

    localparam logic [31:0] ID_VALUE = 32'hCE0E_0001;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, MMIO_RESP} state_t;

    state_t      state;
    logic [31:0] flag;
    logic [31:0] result;
    logic [31:0] cycle_count;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        is_mmio;
    logic        ram_req;
    logic        mmio_gnt;
    logic [1:0]  offset;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

    assign is_mmio  = ((data_addr_i & MMIO_MASK) == MMIO_BASE);
    assign offset   = data_addr_i[3:2];
    // Requests are only considered in IDLE, and never while reset is held.
    assign ram_req  = !rst_i && (state == IDLE) && data_req_i && !is_mmio;
    assign mmio_gnt = !rst_i && (state == IDLE) && data_req_i && is_mmio;

    always_comb begin
        mem_req_o     = ram_req;
        mem_we_o      = ram_req & data_we_i;
        mem_be_o      = ram_req ? data_be_i : 4'b0000;
        mem_addr_o    = ram_req ? data_addr_i : 32'h0;
        mem_wdata_o   = ram_req ? data_wdata_i : 32'h0;
        data_gnt_o    = mmio_gnt | (ram_req & mem_gnt_i);
        data_rvalid_o = 1'b0;
        data_err_o    = 1'b0;
        data_rdata_o  = 32'h0;
        if (!rst_i) begin
            if (state == MEM_WAIT) begin
                data_rvalid_o = mem_rvalid_i;
                data_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0;
            end else if (state == MMIO_RESP) begin
                data_rvalid_o = 1'b1;
                data_err_o    = resp_err;
                data_rdata_o  = resp_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            flag        <= 32'h0;
            result      <= 32'h0;
            cycle_count <= 32'h0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            case (state)
                IDLE: begin
                    if (ram_req && mem_gnt_i) begin
                        state <= MEM_WAIT;
                    end else if (mmio_gnt) begin
                        state      <= MMIO_RESP;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        // Writes answer with zero data; read-only targets flag an error.
                        if (data_we_i) begin
                            case (offset)
                                2'd0:    flag   <= apply_be(flag, data_wdata_i, data_be_i);
                                2'd1:    result <= apply_be(result, data_wdata_i, data_be_i);
                                default: resp_err <= 1'b1;
                            endcase
                        end else begin
                            case (offset)
                                2'd0:    resp_rdata <= flag;
                                2'd1:    resp_rdata <= result;
                                2'd2:    resp_rdata <= cycle_count;
                                default: resp_rdata <= ID_VALUE;
                            endcase
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid_i) state <= IDLE;
                end
                MMIO_RESP: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign flag_o   = flag;
    assign result_o = result;
    assign done_o   = |flag;

endmodule
